// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin flop arbiter family.
// The optional owner lock is enabled by defining RR_ARB_LOCK_EN (see rr_flop_arbiter).
package rr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;

    // Upper bound on requesters supported by the rotate helper.
    localparam int MAX_REQ     = 32;

    // Rotate the low num_req bits of req right by ptr, so that bit 0 of the
    // result is requester ptr, bit 1 is ptr+1 (wrapping), and so on.
    // Bits at or above num_req are returned as zero.
    function automatic logic [MAX_REQ-1:0] rotate_req(
        input logic [MAX_REQ-1:0] req,
        input int                 num_req,
        input int                 ptr
    );
        logic [MAX_REQ-1:0] rot;
        rot = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            rot[i] = (i < num_req) ? req[(i + ptr) % num_req] : 1'b0;
        end
        return rot;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority search: finds the first set request
// at or after ptr_i (ascending, wrapping) and returns it one-hot and as an index.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [MAX_REQ-1:0] rot_s;
    logic               found_s;
    int                 off_s;
    int                 win_s;

    // Rotate so the search always starts at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        rot_s   = rotate_req(MAX_REQ'(req_i), NUM_REQ, int'(ptr_i));
        found_s = |rot_s;
        off_s   = 0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? k : off_s;
        end
        win_s   = (off_s + int'(ptr_i)) % NUM_REQ;
        idx_o   = found_s ? IDX_W'(win_s) : '0;
        gnt_o   = found_s ? (NUM_REQ'(1) << win_s) : '0;
        valid_o = found_s;
    end

endmodule

// File: rtl/rr_flop_arbiter.sv
// Round-robin arbiter sharing one DATA_W register between NUM_REQ requesters.
// The winner's data is loaded at the sampling edge; grant, owner and valid
// are visible the following cycle.
// Optional feature: define RR_ARB_LOCK_EN to add lock_i, which lets the
// current owner keep the grant while it holds both req_i and lock_i.
module rr_flop_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    parameter  int DATA_W  = DATA_W_DEF,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
`ifdef RR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        lock_i,
`endif
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [IDX_W-1:0]          owner_o,
    output logic [DATA_W-1:0]         q_o,
    output logic                      q_valid_o
);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q,   ptr_d;
    logic [NUM_REQ-1:0]   gnt_q,   gnt_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [DATA_W-1:0]    q_q,     q_d;

    logic [NUM_REQ-1:0]   pick_gnt_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic                 pick_valid_s;
    logic                 lock_hold_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt_s),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    // Lock holds only for the live owner; lock bits of other requesters are ignored.
    always_comb begin
`ifdef RR_ARB_LOCK_EN
        lock_hold_s = (state_q == GRANT) && req_i[owner_q] && lock_i[owner_q];
`else
        lock_hold_s = 1'b0;
`endif
    end

    // Next-state: FSM transition plus grant/owner/data/pointer update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        owner_d = owner_q;
        q_d     = q_q;

        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (pick_valid_s) begin
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (lock_hold_s) begin
            // Owner keeps the register; pointer stays so round-robin resumes where it left off.
            gnt_d   = NUM_REQ'(1) << owner_q;
            owner_d = owner_q;
            q_d     = data_i[int'(owner_q)*DATA_W +: DATA_W];
            ptr_d   = ptr_q;
        end else if (pick_valid_s) begin
            gnt_d   = pick_gnt_s;
            owner_d = pick_idx_s;
            q_d     = data_i[int'(pick_idx_s)*DATA_W +: DATA_W];
            ptr_d   = (pick_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : (pick_idx_s + IDX_W'(1));
        end else begin
            // Idle: drop the grant, keep last owner and data for observers.
            gnt_d   = '0;
            owner_d = owner_q;
            q_d     = q_q;
            ptr_d   = ptr_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            owner_q <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            q_q     <= q_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign owner_o   = owner_q;
    assign q_o       = q_q;
    assign q_valid_o = (state_q == GRANT);

endmodule

// File: doc/rr_flop_arbiter.md
Name: rr_flop_arbiter

Overview:
- Round-robin arbiter that shares one DATA_W-wide register between NUM_REQ requesters.
- Each cycle, at most one requester wins and its data is loaded into the shared register. The winner is reported one cycle later.
- Sits in front of any single-register resource: a shared status flop, a config register, or a single-entry mailbox.

Parameters:
- NUM_REQ, 4, number of requesters; must be ≥2.
- DATA_W, 8, width of each requester's data and of the shared register.
- IDX_W, $clog2(NUM_REQ), width of the owner index (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester request; bit i belongs to requester i.
- data_i  input  NUM_REQ*DATA_W  packed data; requester i uses bits [i*DATA_W +: DATA_W].
- gnt_o  output  NUM_REQ  registered one-hot grant; all zero when idle.
- owner_o  output  IDX_W  index of the current grant holder; meaningful only while q_valid_o=1.
- q_o  output  DATA_W  shared register contents.
- q_valid_o  output  1  high for the cycle following a grant.

Behaviour:
- Reset: clk and reset are the only clock and reset; reset is synchronous and active-high. While reset=1 at a posedge, all of the following load zero: gnt_o, owner_o, q_o, q_valid_o, and the priority pointer ptr. Reset overrides any request in that cycle. Reset asserted mid-grant drops the grant on the next edge; nothing is retained.
- Arbitration: combinational search of req_i starting at index ptr, ascending, wrapping NUM_REQ-1 to 0. The first set bit is the winner w.
- Latency: req_i and data_i are sampled at edge t. At edge t the register loads gnt_o=onehot(w), owner_o=w, q_o=data_i[w], q_valid_o=1, and ptr=(w+1) mod NUM_REQ. These values are visible during cycle t+1.
- No request: gnt_o=0, q_valid_o=0, and ptr holds. q_o and owner_o hold their last values; q_o is not cleared.
- Fairness: a requester holding req_i continuously is granted within NUM_REQ cycles. Two requesters that both hold req_i alternate.
- Pointer wrap: a win by NUM_REQ-1 sets ptr=0. No out-of-range ptr value is reachable.
- Request drop: a requester deasserting req_i in the same cycle as its grant is legal. The next cycle rearbitrates normally.
- State machine: IDLE (q_valid_o=0) and GRANT (q_valid_o=1).
  - IDLE to GRANT on any req_i.
  - GRANT to GRANT on any req_i; the winner is re-evaluated every cycle.
  - GRANT to IDLE when req_i is all zero.
  - Any state to IDLE on reset.
- Invariant: gnt_o is always one-hot or zero.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- With the macro defined:
  - Adds port lock_i, input, NUM_REQ.
  - If the current owner o has req_i[o]=1 and lock_i[o]=1, the grant stays with o. q_o reloads data_i[o] and ptr is not advanced.
  - The lock ends when the owner drops req_i[o] or lock_i[o]; normal round-robin then resumes from the held ptr.
  - lock_i from non-owners is ignored.
- Without the macro: no lock_i port; pure round-robin every cycle.

Decomposition:
- Shared package rr_arb_pkg holds:
  - an arb_state_t enum {IDLE, GRANT};
  - the default constants NUM_REQ_DEF=4 and DATA_W_DEF=8;
  - a function that rotates the request vector by ptr.
- One sub-module: rr_pick, a purely combinational priority search. It takes req and ptr and returns a one-hot and an index; it is reusable by other arbiters.
- Registers and the FSM live in the top.

Test Plan:
- Reset, then req_i=0 for 5 cycles → gnt_o=0, q_valid_o=0, q_o=0, owner_o=0.
- req_i=4'b1111, data_i={8'h44,8'h33,8'h22,8'h11} held 8 cycles → owner sequence 0,1,2,3,0,1,2,3; q_o 11,22,33,44 repeating; q_valid_o=1 throughout.
- req_i=4'b1000 for one cycle, then 4'b1001 → grant 3 (q_o=data3), then ptr=0 gives grant 0, then grant 3. This exercises the wrap.
- req_i=4'b0110 continuously, with reset=1 asserted for one cycle mid-stream → the next edge shows all outputs 0. After reset releases, the first grant goes to 1 (ptr reset to 0, search begins at 0).
- req_i all zero after a grant to 2 with q_o=8'hA5 → q_valid_o=0 and gnt_o=0, while q_o stays 8'hA5 and owner_o stays 2.
- With RR_ARB_LOCK_EN: req_i=4'b0011, lock_i=4'b0001 for 3 cycles, then lock_i=0 → owner 0,0,0,1. With the macro undefined, the same stimulus gives 0,1,0,1.
